// File: rtl/ps2_kb_rx_fifo.sv
// PS/2 keyboard receiver: synchronize and filter the PS/2 lines, deframe 11-bit odd-parity frames,
// buffer good scan codes in a first-word-fall-through FIFO. Optional PS2_BREAK_FILTER_EN drops breaks.
module ps2_kb_rx_fifo #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_AW        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rd_en,
    output logic [7:0] key_code,
    output logic       kb_not_empty,
    output logic       kb_full,
    output logic       parity_err,
    output logic       overrun
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0]    TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW:0]   DepthC  = (FIFO_AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // ---------------- input conditioning ----------------
    logic [1:0]            c_sync_q, d_sync_q;
    logic [FILTER_LEN-1:0] taps_q, taps_d;
    logic                  filt_q, filt_d;
    logic                  fall_q;
    logic                  ps2c_s, ps2d_s;

    assign ps2c_s = c_sync_q[1];
    assign ps2d_s = d_sync_q[1];
    assign taps_d = {taps_q[FILTER_LEN-2:0], ps2c_s};

    always_comb begin
        filt_d = filt_q;
        if (&taps_d) begin
            filt_d = 1'b1;
        end else if (~|taps_d) begin
            filt_d = 1'b0;
        end
    end

    // Idle PS/2 lines are high, so the conditioning chain resets to 1 to avoid a spurious fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            taps_q   <= '1;
            filt_q   <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c};
            d_sync_q <= {d_sync_q[0], ps2d};
            taps_q   <= taps_d;
            filt_q   <= filt_d;
            fall_q   <= filt_q & ~filt_d;
        end
    end

    // ---------------- frame FSM ----------------
    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            frame_ok, frame_bad;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;

        if (state_q == StIdle || fall_q) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        if (state_q != StIdle && !fall_q && tmo_q == TmoLast) begin
            // Keyboard stalled mid-frame: drop the partial byte silently.
            state_d = StIdle;
            tmo_d   = '0;
        end else if (fall_q) begin
            case (state_q)
                StIdle: begin
                    if (!ps2d_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {ps2d_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = ps2d_s;
                    state_d = StStop;
                end
                StStop: begin
                    if ((^shift_q ^ par_q) && ps2d_s) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    // ---------------- optional break-code filter ----------------
    logic push_req;

`ifdef PS2_BREAK_FILTER_EN
    logic brk_q, brk_d;

    // 0xF0 arms brk; the byte after it is the released key and is swallowed too.
    always_comb begin
        brk_d    = brk_q;
        push_req = 1'b0;
        if (frame_ok) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else begin
                push_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end
`else
    assign push_req = frame_ok;
`endif

    // ---------------- scan-code FIFO ----------------
    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_now, empty_now;
    logic               push, pop;
    logic               not_empty_q, full_q, perr_q, ovr_q;

    assign full_now  = (count_q == DepthC);
    assign empty_now = (count_q == '0);
    assign pop       = rd_en && !empty_now;
    assign push      = push_req && (!full_now || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            not_empty_q <= 1'b0;
            full_q      <= 1'b0;
            perr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            count_q     <= count_d;
            not_empty_q <= (count_d != '0);
            full_q      <= (count_d == DepthC);
            perr_q      <= frame_bad;
            ovr_q       <= push_req && full_now && !pop;
        end
    end

    assign key_code     = mem_q[rd_ptr_q];
    assign kb_not_empty = not_empty_q;
    assign kb_full      = full_q;
    assign parity_err   = perr_q;
    assign overrun      = ovr_q;

endmodule
